// File: rtl/motor_output_bank.sv
// Multi-channel ESC output bank: one shared timing engine drives every motor line
// with either a standard PWM pulse or a DShot digital frame, all channels in lockstep.
module motor_output_bank #(
    parameter int NUM_MOTORS      = 4,
    parameter int VAL_W           = 11,
    parameter int DSHOT_BIT_CLKS  = 27,
    parameter int DSHOT_T0H_CLKS  = 10,
    parameter int DSHOT_T1H_CLKS  = 20,
    parameter int DSHOT_GAP_CLKS  = 32,
    parameter int PWM_BASE_CLKS   = 16000,
    parameter int PWM_STEP_CLKS   = 8,
    parameter int PWM_MAX_VAL     = 2000,
    parameter int PWM_PERIOD_CLKS = 40000
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic                        MODE,
    input  logic                        ARM,
    input  logic [NUM_MOTORS*VAL_W-1:0] VALUES,
    input  logic                        UPDATE,
    output logic                        READY,
    output logic [NUM_MOTORS-1:0]       MOTOR
);

    localparam int CNT_W   = $clog2(PWM_PERIOD_CLKS);
    localparam int HI_W    = CNT_W + 1;
    localparam int FRAME_W = VAL_W + 5;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(DSHOT_BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DSHOT_GAP_CLKS - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PWM_PERIOD_CLKS - 1);
    localparam logic [CNT_W-1:0] T0H         = CNT_W'(DSHOT_T0H_CLKS);
    localparam logic [CNT_W-1:0] T1H         = CNT_W'(DSHOT_T1H_CLKS);
    localparam logic [BIT_W-1:0] FRAME_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE     = BIT_W'(1);
    localparam logic [VAL_W-1:0] PWM_MAX     = VAL_W'(PWM_MAX_VAL);

    typedef enum logic [2:0] {
        IDLE,
        DS_BIT,
        DS_GAP,
        PWM_HIGH,
        PWM_LOW
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]              bit_cnt_q, bit_cnt_d;
    logic [NUM_MOTORS*VAL_W-1:0]   vals_q, vals_d;
    logic [NUM_MOTORS-1:0]         motor_q, motor_d;
    logic [NUM_MOTORS-1:0]         pwm_continue;
    logic                          accept;

    assign READY  = (state_q == IDLE);
    assign accept = UPDATE && READY;
    assign MOTOR  = motor_q;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        vals_d    = vals_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    vals_d    = ARM ? VALUES : '0;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = MODE ? DS_BIT : PWM_HIGH;
                end
            end
            DS_BIT: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == FRAME_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = DS_GAP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            DS_GAP: begin
                if (clk_cnt_q == GAP_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            PWM_HIGH: begin
                // The counter keeps running through the low phase so the period stays fixed.
                clk_cnt_d = clk_cnt_q + CNT_ONE;
                if (pwm_continue == '0) begin
                    state_d = PWM_LOW;
                end
            end
            PWM_LOW: begin
                if (clk_cnt_q == PERIOD_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-channel waveform is derived from next-cycle state so MOTOR can be a clean flop,
    // and from vals_d so the very first bit after acceptance already uses the new command.
    for (genvar ch = 0; ch < NUM_MOTORS; ch++) begin : g_ch
        logic [VAL_W-1:0]   val;
        logic [VAL_W-1:0]   val_clamped;
        logic [VAL_W:0]     v12;
        logic [3:0]         crc;
        logic [FRAME_W-1:0] frame;
        logic               cur_bit;
        logic [CNT_W-1:0]   bit_high;
        logic [HI_W-1:0]    high_clks;

        assign val         = vals_d[ch*VAL_W +: VAL_W];
        assign v12         = {val, 1'b0};
        assign crc         = v12[3:0] ^ v12[7:4] ^ v12[11:8];
        assign frame       = {v12, crc};
        assign cur_bit     = frame[FRAME_LAST - bit_cnt_d];
        assign bit_high    = cur_bit ? T1H : T0H;
        assign val_clamped = (val > PWM_MAX) ? PWM_MAX : val;
        assign high_clks   = HI_W'(PWM_BASE_CLKS) + HI_W'(val_clamped) * HI_W'(PWM_STEP_CLKS);

        assign pwm_continue[ch] = (HI_W'(clk_cnt_q) + HI_W'(1)) < high_clks;

        assign motor_d[ch] = (state_d == DS_BIT)                          ? (clk_cnt_d < bit_high) :
                             (state_d == PWM_HIGH || state_d == PWM_LOW)  ? (HI_W'(clk_cnt_d) < high_clks) :
                                                                            1'b0;
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            // NOTE: the latched command registers are reset too, so a post-reset frame never sees stale data.
            vals_q    <= '0;
            motor_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            vals_q    <= vals_d;
            motor_q   <= motor_d;
        end
    end

endmodule

// File: tb/tb_motor_output_bank.sv
// Self-checking bench for motor_output_bank: captures each frame's MOTOR waveform and
// compares it with an arithmetic reference built directly from the DShot/PWM rules.
module tb_motor_output_bank;

    localparam int NM    = 4;
    localparam int VW    = 11;
    localparam int LIMIT = 41000;

    logic              clk;
    logic              rst_n;
    logic              mode;
    logic              arm;
    logic [NM*VW-1:0]  values;
    logic              update;
    logic              ready;
    logic [NM-1:0]     motor;

    int unsigned n_tot;
    int unsigned n_bad;

    logic [NM-1:0] wave [LIMIT];
    int            busy;
    bit            cur_mode;
    bit            cur_arm;
    int            cur_val [NM];

    motor_output_bank dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .MODE    (mode),
        .ARM     (arm),
        .VALUES  (values),
        .UPDATE  (update),
        .READY   (ready),
        .MOTOR   (motor)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on the frame rules.
    function automatic int model_frame(input int v);
        int v12;
        int crc;
        v12 = v * 2;
        crc = (v12 ^ (v12 >> 4) ^ (v12 >> 8)) & 15;
        return v12 * 16 + crc;
    endfunction

    function automatic int model_high(input int v);
        return 16000 + 8 * ((v > 2000) ? 2000 : v);
    endfunction

    function automatic bit model_level(input bit m, input int v, input int k);
        int b;
        if (m) begin
            if (k >= 16 * 27) return 1'b0;
            b = (model_frame(v) >> (15 - k / 27)) & 1;
            return (k % 27) < ((b != 0) ? 20 : 10);
        end
        return k < model_high(v);
    endfunction

    function automatic int model_busy(input bit m);
        return m ? 16 * 27 + 32 : 40000;
    endfunction

    task automatic randomize_vals();
        for (int i = 0; i < NM; i++) cur_val[i] = int'($urandom_range(0, 2047));
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (motor !== '0 || ready !== 1'b1) bad++;
            @(negedge clk);
        end
        check(tag, bad, 0);
    endtask

    // Called at a negedge; leaves the bench at sample 0 of the new frame.
    task automatic start_frame(input string name);
        check({name, "_ready_at_start"}, ready, 1);
        mode = cur_mode;
        arm  = cur_arm;
        for (int i = 0; i < NM; i++) values[i*VW +: VW] = VW'(cur_val[i]);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    // Records MOTOR until READY returns; optionally pulses UPDATE with unrelated data mid-frame.
    task automatic capture(input string name, input int poke_at);
        busy = -1;
        for (int k = 0; k < LIMIT; k++) begin
            if (ready === 1'b1) begin
                busy = k;
                break;
            end
            wave[k] = motor;
            if (k == poke_at) begin
                mode   = ~cur_mode;
                arm    = 1'b1;
                values = (NM*VW)'({$urandom(), $urandom()});
                update = 1'b1;
            end else begin
                update = 1'b0;
            end
            @(negedge clk);
        end
        update = 1'b0;
        check({name, "_busy_len"}, busy, model_busy(cur_mode));
    endtask

    task automatic verify(input string name);
        int eff;
        int mism;
        int word;
        int cnt;
        int w;
        for (int ch = 0; ch < NM; ch++) begin
            eff  = cur_arm ? cur_val[ch] : 0;
            mism = 0;
            for (int k = 0; k < model_busy(cur_mode); k++) begin
                if (wave[k][ch] !== model_level(cur_mode, eff, k)) mism++;
            end
            check($sformatf("%s_ch%0d_wave_mismatches", name, ch), mism, 0);
            if (cur_mode) begin
                word = 0;
                for (int b = 0; b < 16; b++) begin
                    cnt = 0;
                    for (int j = 0; j < 27; j++) cnt += (wave[b*27 + j][ch] === 1'b1) ? 1 : 0;
                    word = (word << 1) | ((cnt >= 15) ? 1 : 0);
                end
                check($sformatf("%s_ch%0d_dshot_word", name, ch), word, model_frame(eff));
            end else begin
                w = 0;
                while (w < 40000 && wave[w][ch] === 1'b1) w++;
                check($sformatf("%s_ch%0d_pwm_high", name, ch), w, model_high(eff));
            end
        end
    endtask

    task automatic run_frame(input string name, input int poke_at);
        start_frame(name);
        capture(name, poke_at);
        verify(name);
    endtask

    initial begin
        n_tot  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        mode   = 1'b0;
        arm    = 1'b0;
        values = '0;
        update = 1'b0;

        #12;
        check("reset_motor", motor, 0);
        check("reset_ready", ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_check("idle_after_reset", 60);

        cur_mode = 1'b1;
        cur_arm  = 1'b1;
        cur_val  = '{1046, 48, 0, 2047};
        run_frame("ds_crc", -1);

        cur_mode = 1'b0;
        cur_val  = '{0, 1000, 2000, 2047};
        run_frame("pwm_width", -1);

        cur_mode = 1'b1;
        cur_arm  = 1'b0;
        cur_val  = '{1500, 1500, 1500, 1500};
        run_frame("ds_disarm", -1);
        cur_mode = 1'b0;
        run_frame("pwm_disarm", -1);

        // Busy UPDATE with new data and PWM mode must be dropped, not queued.
        cur_mode = 1'b1;
        cur_arm  = 1'b1;
        randomize_vals();
        run_frame("ds_busy_poke", 200);
        idle_check("no_queued_frame", 30);

        // Second frame is requested on the very cycle READY comes back.
        randomize_vals();
        run_frame("ds_chain_a", -1);
        randomize_vals();
        run_frame("ds_chain_b", -1);

        // Reset in the high part of bit 5, then a clean full frame.
        randomize_vals();
        start_frame("ds_reset");
        repeat (5 * 27 + 2) @(negedge clk);
        check("pre_reset_high", motor, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_motor", motor, 0);
        check("reset_mid_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_check("idle_after_mid_reset", 5);
        randomize_vals();
        run_frame("ds_after_reset", -1);

        for (int r = 0; r < 4; r++) begin
            cur_arm = ($urandom_range(0, 3) != 0);
            randomize_vals();
            run_frame($sformatf("ds_rand%0d", r), -1);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
